// File: rtl/ide_xfer_sequencer_pkg.sv
// Shared types and constants for the IDE transfer sequencer: FSM states,
// IDE register offsets and the status/flag byte values it writes.
package ide_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FILL,
    S_ARM_CTL,
    S_ARM_POS,
    S_ARM_TGT,
    S_ARM_STS,
    S_WAIT,
    S_ACK,
    S_ERR_REG,
    S_FIN
  } seq_state_t;

  localparam logic [9:0] REG_STATUS_IRQ = 10'h000;
  localparam logic [9:0] REG_ERROR      = 10'h001;
  localparam logic [9:0] REG_IOCONTROL  = 10'h002;
  localparam logic [9:0] REG_IOPOS      = 10'h003;
  localparam logic [9:0] REG_IOTARGET   = 10'h005;
  localparam logic [9:0] REG_FLAGS      = 10'h006;
  localparam logic [9:0] BUF_BASE       = 10'h200;

  localparam logic [7:0] STS_ARMED     = 8'h58;
  localparam logic [7:0] STS_ABORTED   = 8'h51;
  localparam logic [7:0] ERR_ABORT     = 8'h04;
  localparam logic [7:0] FLAG_DATA_CLR = 8'h20;

  localparam int FLAG_DATA_BIT = 5;

  function automatic logic [9:0] buf_addr(input logic [8:0] idx);
    return BUF_BASE + {1'b0, idx};
  endfunction

endpackage

// File: rtl/ide_xfer_sequencer_if.sv
// CPU-side and IDE-side register/buffer buses shared by the sequencer and
// its port arbiter; master is the sequencer view, slave the environment view.
interface ide_xfer_sequencer_if;

  logic [9:0] cpu_a;
  logic [7:0] cpu_d_in;
  logic       cpu_cs;
  logic       cpu_oe;
  logic       cpu_we;
  logic [7:0] cpu_d_out;
  logic       cpu_wait;

  logic [9:0] ide_a;
  logic [7:0] ide_d_out;
  logic       ide_cs;
  logic       ide_oe;
  logic       ide_we;
  logic [7:0] ide_d_in;
  logic       ide_wait;

  modport master (
    input  cpu_a, cpu_d_in, cpu_cs, cpu_oe, cpu_we, ide_d_in, ide_wait,
    output cpu_d_out, cpu_wait, ide_a, ide_d_out, ide_cs, ide_oe, ide_we
  );

  modport slave (
    output cpu_a, cpu_d_in, cpu_cs, cpu_oe, cpu_we, ide_d_in, ide_wait,
    input  cpu_d_out, cpu_wait, ide_a, ide_d_out, ide_cs, ide_oe, ide_we
  );

endinterface

// File: rtl/ide_xfer_sequencer_port_arbiter.sv
// IDE port mux: the sequencer wins any cycle it issues an access, otherwise
// the CPU bus passes straight through; the CPU is stalled while it loses.
module ide_seq_port_arbiter (
  input  logic                        rst,
  input  logic                        i_seq_own,
  input  logic [9:0]                  i_seq_a,
  input  logic [7:0]                  i_seq_d,
  input  logic                        i_seq_oe,
  input  logic                        i_seq_we,
  ide_xfer_sequencer_if.master        bus
);

  always_comb begin
    bus.cpu_wait  = bus.cpu_cs & (i_seq_own | bus.ide_wait);
    bus.cpu_d_out = i_seq_own ? 8'h00 : bus.ide_d_in;
    bus.ide_cs    = 1'b0;
    bus.ide_oe    = 1'b0;
    bus.ide_we    = 1'b0;
    bus.ide_a     = 10'h000;
    bus.ide_d_out = 8'h00;
    // Reset keeps the port released even if the CPU side is still active.
    if (i_seq_own) begin
      bus.ide_cs    = 1'b1;
      bus.ide_oe    = i_seq_oe;
      bus.ide_we    = i_seq_we;
      bus.ide_a     = i_seq_a;
      bus.ide_d_out = i_seq_d;
    end else if (!rst) begin
      bus.ide_cs    = bus.cpu_cs;
      bus.ide_oe    = bus.cpu_oe;
      bus.ide_we    = bus.cpu_we;
      bus.ide_a     = bus.cpu_a;
      bus.ide_d_out = bus.cpu_d_in;
    end
  end

endmodule

// File: rtl/ide_xfer_sequencer.sv
// Chunked IDE buffer-fill / handshake sequencer with CPU pass-through.
// Optional macro IDE_SEQ_WATCHDOG_EN adds a WAIT-state timeout that acts as abort.
module ide_xfer_sequencer
  import ide_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ide_xfer_sequencer_if.master bus,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           nchunks,
  input  logic [7:0]           chunk_words,
  input  logic [7:0]           final_status,
  input  logic [7:0]           src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  seq_state_t r_state;
  seq_state_t w_next;
  logic [8:0] r_byte_idx;
  logic [7:0] r_chunks;
  logic [7:0] r_wm1;
  logic [7:0] r_final;
  logic       r_err;
  logic       r_done;

  logic       w_abort;
  logic       w_accept;
  logic       w_last_byte;
  logic       w_own;
  logic [9:0] w_a;
  logic [7:0] w_d;
  logic       w_oe;
  logic       w_we;

`ifdef IDE_SEQ_WATCHDOG_EN
  logic [15:0] r_wdog;
  logic        w_wdog_expired;

  assign w_wdog_expired = (r_state == S_WAIT) && (r_wdog == 16'hFFFE);
  assign w_abort        = abort | w_wdog_expired;

  // Held at zero outside WAIT so every WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT) r_wdog <= 16'h0000;
    else                          r_wdog <= r_wdog + 16'h0001;
  end
`else
  assign w_abort = abort;
`endif

  assign src_ready   = (r_state == S_FILL) && !w_abort;
  assign w_accept    = src_ready && src_valid;
  assign w_last_byte = (r_byte_idx == {r_wm1, 1'b1});
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;

  always_comb begin
    w_next = r_state;
    w_own  = 1'b0;
    w_a    = 10'h000;
    w_d    = 8'h00;
    w_oe   = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = (nchunks == 8'd0) ? S_FIN : S_FILL;
      S_FILL: begin
        if (w_accept) begin
          {w_own, w_we, w_a, w_d} = {1'b1, 1'b1, buf_addr(r_byte_idx), src_data};
          if (w_last_byte) w_next = S_ARM_CTL;
        end
      end
      S_ARM_CTL: begin
        {w_own, w_we, w_a, w_d} = {1'b1, 1'b1, REG_IOCONTROL, 8'h00};
        w_next = S_ARM_POS;
      end
      S_ARM_POS: begin
        {w_own, w_we, w_a, w_d} = {1'b1, 1'b1, REG_IOPOS, 8'h00};
        w_next = S_ARM_TGT;
      end
      S_ARM_TGT: begin
        {w_own, w_we, w_a, w_d} = {1'b1, 1'b1, REG_IOTARGET, r_wm1};
        w_next = S_ARM_STS;
      end
      S_ARM_STS: begin
        {w_own, w_we, w_a, w_d} = {1'b1, 1'b1, REG_STATUS_IRQ, STS_ARMED};
        w_next = S_WAIT;
      end
      S_WAIT: begin
        {w_own, w_oe, w_a} = {1'b1, 1'b1, REG_FLAGS};
        if (bus.ide_d_in[FLAG_DATA_BIT]) w_next = S_ACK;
      end
      S_ACK: begin
        {w_own, w_we, w_a, w_d} = {1'b1, 1'b1, REG_FLAGS, FLAG_DATA_CLR};
        w_next = (r_chunks <= 8'd1) ? S_FIN : S_FILL;
      end
      S_ERR_REG: begin
        {w_own, w_we, w_a, w_d} = {1'b1, 1'b1, REG_ERROR, ERR_ABORT};
        w_next = S_FIN;
      end
      S_FIN: begin
        {w_own, w_we, w_a} = {1'b1, 1'b1, REG_STATUS_IRQ};
        w_d    = r_err ? STS_ABORTED : r_final;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
    if (w_abort && r_state != S_IDLE) w_next = S_ERR_REG;
  end

  // Job parameters are latched on start; chunk_words of 0 wraps to 0xFF = 256 words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_idx <= 9'd0;
      r_chunks   <= 8'd0;
      r_wm1      <= 8'd0;
      r_final    <= 8'd0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_FIN) && (w_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chunks   <= nchunks;
            r_wm1      <= chunk_words - 8'd1;
            r_final    <= final_status;
            r_err      <= 1'b0;
            r_byte_idx <= 9'd0;
          end
        end
        S_FILL:  if (w_accept && !w_last_byte) r_byte_idx <= r_byte_idx + 9'd1;
        S_ACK: begin
          r_byte_idx <= 9'd0;
          if (r_chunks != 8'd0) r_chunks <= r_chunks - 8'd1;
        end
        default: ;
      endcase
      if (w_next == S_ERR_REG) r_err <= 1'b1;
    end
  end

  ide_seq_port_arbiter u_arbiter (
    .rst       (rst),
    .i_seq_own (w_own),
    .i_seq_a   (w_a),
    .i_seq_d   (w_d),
    .i_seq_oe  (w_oe),
    .i_seq_we  (w_we),
    .bus       (bus)
  );

endmodule

// File: tb/tb_ide_xfer_sequencer.sv
// Scoreboard bench for ide_xfer_sequencer: expected IDE writes are queued as
// stimulus is driven and matched against writes captured from the port.
module tb_ide_xfer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [7:0] nchunks, chunkWords, finalStatus;
  logic [7:0] srcData;
  logic       srcValid;
  logic       srcReady, busy, done, err;

  ide_xfer_sequencer_if bus ();

  ide_xfer_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .start        (start),
    .abort        (abort),
    .nchunks      (nchunks),
    .chunk_words  (chunkWords),
    .final_status (finalStatus),
    .src_data     (srcData),
    .src_valid    (srcValid),
    .src_ready    (srcReady),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  logic [17:0] expQ[$];
  logic [17:0] obsQ[$];
  int          checkCount = 0;
  int          passCount  = 0;
  logic        devFlag    = 1'b0;
  logic        autoFlag   = 1'b0;

  // Device model: flag register at 0x006, every other address reads a fixed pattern.
  always_comb begin
    bus.ide_d_in = bus.ide_a[7:0] ^ 8'h5A;
    if (bus.ide_a == 10'h006) bus.ide_d_in = {2'b00, devFlag, 5'b00000};
  end

  always @(negedge clk) begin
    if (busy && bus.ide_cs && bus.ide_we) begin
      obsQ.push_back({bus.ide_a, bus.ide_d_out});
      if (autoFlag && bus.ide_a == 10'h000 && bus.ide_d_out == 8'h58) devFlag = 1'b1;
      if (bus.ide_a == 10'h006 && bus.ide_d_out[5]) devFlag = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startJob(input logic [7:0] n, input logic [7:0] cw, input logic [7:0] fs);
    tick();
    start = 1'b1; nchunks = n; chunkWords = cw; finalStatus = fs;
    tick();
    start = 1'b0;
  endtask

  task automatic sendBytes(input int count, input logic [7:0] first, input int gapPct);
    logic [7:0] b;
    int         waitCnt;
    for (int i = 0; i < count; i++) begin
      if (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
        srcValid = 1'b0;
        tick();
      end
      b = first + 8'(i);
      srcData  = b;
      srcValid = 1'b1;
      expQ.push_back({10'h200 + 10'(i), b});
      waitCnt = 0;
      @(negedge clk);
      while (!srcReady && waitCnt < 100) begin
        waitCnt++;
        @(negedge clk);
      end
      if (waitCnt >= 100) begin
        checkCount++;
        $display("[TB] FAIL src_accept: byte %0d not accepted, got src_ready=0, expected 1", i);
      end
      tick();
    end
    srcValid = 1'b0;
  endtask

  task automatic pushArm(input logic [7:0] wm1);
    expQ.push_back({10'h002, 8'h00});
    expQ.push_back({10'h003, 8'h00});
    expQ.push_back({10'h005, wm1});
    expQ.push_back({10'h000, 8'h58});
  endtask

  task automatic waitDone(input int maxCycles, output bit seen, output logic errAt, output logic busyAt);
    seen = 1'b0; errAt = 1'bx; busyAt = 1'bx;
    for (int c = 0; c < maxCycles && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; errAt = err; busyAt = busy;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checkCount++;
    if ({busy, done, err, srcReady} !== 4'b0000)
      $display("[TB] FAIL reset_status: got busy/done/err/rdy=%b, expected 0000", {busy, done, err, srcReady});
    else passCount++;
    checkCount++;
    if ({bus.ide_cs, bus.ide_oe, bus.ide_we, bus.ide_a, bus.ide_d_out} !== 21'd0)
      $display("[TB] FAIL reset_port: got cs/oe/we=%b a=%h d=%h, expected all 0",
               {bus.ide_cs, bus.ide_oe, bus.ide_we}, bus.ide_a, bus.ide_d_out);
    else passCount++;
  endtask

  task automatic test_single_chunk();
    bit seen; logic e, b; logic [17:0] ex, ob;
    devFlag = 1'b0; autoFlag = 1'b1;
    startJob(8'd1, 8'd2, 8'h3C);
    checkCount++;
    if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b, expected 1", busy);
    else passCount++;
    sendBytes(4, 8'hA1, 0);
    start = 1'b1; nchunks = 8'd9;
    tick();
    start = 1'b0;
    pushArm(8'h01);
    expQ.push_back({10'h006, 8'h20});
    expQ.push_back({10'h000, 8'h3C});
    waitDone(200, seen, e, b);
    checkCount++;
    if (seen !== 1'b1 || {e, b} !== 2'b00)
      $display("[TB] FAIL single_done: got seen=%b err=%b busy=%b, expected 1 0 0", seen, e, b);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (done !== 1'b0) $display("[TB] FAIL single_done_pulse: got %b, expected 0", done);
    else passCount++;
    while (expQ.size() > 0) begin
      ex = expQ.pop_front();
      checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL single_write: got none, expected a=%h d=%h", ex[17:8], ex[7:0]);
      else begin
        ob = obsQ.pop_front();
        if (ob !== ex) $display("[TB] FAIL single_write: got a=%h d=%h, expected a=%h d=%h", ob[17:8], ob[7:0], ex[17:8], ex[7:0]);
        else passCount++;
      end
    end
    checkCount++;
    if (obsQ.size() != 0) $display("[TB] FAIL single_extra: got %0d extra writes, expected 0", obsQ.size());
    else passCount++;
    obsQ.delete();
  endtask

  task automatic test_multi_chunk_256();
    bit seen; logic e, b; logic [17:0] ex, ob;
    devFlag = 1'b0; autoFlag = 1'b1;
    startJob(8'd3, 8'd0, 8'hC3);
    for (int c = 0; c < 3; c++) begin
      sendBytes(512, 8'(c * 7), 20);
      pushArm(8'hFF);
      expQ.push_back({10'h006, 8'h20});
    end
    expQ.push_back({10'h000, 8'hC3});
    waitDone(300, seen, e, b);
    checkCount++;
    if (seen !== 1'b1 || {e, b} !== 2'b00)
      $display("[TB] FAIL multi_done: got seen=%b err=%b busy=%b, expected 1 0 0", seen, e, b);
    else passCount++;
    while (expQ.size() > 0) begin
      ex = expQ.pop_front();
      checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL multi_write: got none, expected a=%h d=%h", ex[17:8], ex[7:0]);
      else begin
        ob = obsQ.pop_front();
        if (ob !== ex) $display("[TB] FAIL multi_write: got a=%h d=%h, expected a=%h d=%h", ob[17:8], ob[7:0], ex[17:8], ex[7:0]);
        else passCount++;
      end
    end
    checkCount++;
    if (obsQ.size() != 0) $display("[TB] FAIL multi_extra: got %0d extra writes, expected 0", obsQ.size());
    else passCount++;
    obsQ.delete();
  endtask

  task automatic test_cpu_arbitration();
    bit seen, found; logic e, b; logic [17:0] ex, ob;
    devFlag = 1'b0; autoFlag = 1'b1;
    startJob(8'd2, 8'd1, 8'h11);
    bus.cpu_cs = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_a = 10'h000;
    sendBytes(2, 8'h10, 0);
    pushArm(8'h00);
    expQ.push_back({10'h006, 8'h20});
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (bus.ide_we && bus.ide_a == 10'h000 && bus.ide_d_out == 8'h58) found = 1'b1;
    end
    checkCount++;
    if (found !== 1'b1 || {bus.cpu_wait, bus.cpu_d_out} !== 9'h100)
      $display("[TB] FAIL cpu_stall_arm: got found=%b wait=%b d=%h, expected 1 1 00", found, bus.cpu_wait, bus.cpu_d_out);
    else passCount++;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (!bus.cpu_wait) found = 1'b1;
    end
    checkCount++;
    if (found !== 1'b1 || bus.cpu_d_out !== 8'h5A)
      $display("[TB] FAIL cpu_read_data: got released=%b d=%h, expected 1 5a", found, bus.cpu_d_out);
    else passCount++;
    checkCount++;
    if ({bus.ide_cs, bus.ide_oe, bus.ide_we, bus.ide_a} !== {3'b110, 10'h000})
      $display("[TB] FAIL cpu_passthru_read: got cs/oe/we=%b a=%h, expected 110 000", {bus.ide_cs, bus.ide_oe, bus.ide_we}, bus.ide_a);
    else passCount++;
    tick();
    sendBytes(2, 8'h20, 0);
    pushArm(8'h00);
    expQ.push_back({10'h006, 8'h20});
    expQ.push_back({10'h000, 8'h11});
    waitDone(200, seen, e, b);
    checkCount++;
    if (seen !== 1'b1 || {e, b} !== 2'b00)
      $display("[TB] FAIL cpu_job_done: got seen=%b err=%b busy=%b, expected 1 0 0", seen, e, b);
    else passCount++;
    tick();
    bus.cpu_a = 10'h201; bus.ide_wait = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({bus.cpu_wait, bus.ide_a, bus.ide_oe} !== {1'b1, 10'h201, 1'b1})
      $display("[TB] FAIL cpu_ide_wait_hi: got wait=%b a=%h oe=%b, expected 1 201 1", bus.cpu_wait, bus.ide_a, bus.ide_oe);
    else passCount++;
    tick();
    bus.ide_wait = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({bus.cpu_wait, bus.cpu_d_out} !== {1'b0, 8'h5B})
      $display("[TB] FAIL cpu_ide_wait_lo: got wait=%b d=%h, expected 0 5b", bus.cpu_wait, bus.cpu_d_out);
    else passCount++;
    tick();
    bus.cpu_oe = 1'b0; bus.cpu_we = 1'b1; bus.cpu_d_in = 8'h77;
    @(negedge clk);
    checkCount++;
    if ({bus.ide_we, bus.ide_d_out, bus.cpu_wait} !== {1'b1, 8'h77, 1'b0})
      $display("[TB] FAIL cpu_write_passthru: got we=%b d=%h wait=%b, expected 1 77 0", bus.ide_we, bus.ide_d_out, bus.cpu_wait);
    else passCount++;
    tick();
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_a = 10'h000; bus.cpu_d_in = 8'h00;
    while (expQ.size() > 0) begin
      ex = expQ.pop_front();
      checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL cpu_write_seq: got none, expected a=%h d=%h", ex[17:8], ex[7:0]);
      else begin
        ob = obsQ.pop_front();
        if (ob !== ex) $display("[TB] FAIL cpu_write_seq: got a=%h d=%h, expected a=%h d=%h", ob[17:8], ob[7:0], ex[17:8], ex[7:0]);
        else passCount++;
      end
    end
    checkCount++;
    if (obsQ.size() != 0) $display("[TB] FAIL cpu_extra: got %0d extra writes, expected 0", obsQ.size());
    else passCount++;
    obsQ.delete();
  endtask

  task automatic test_abort_and_zero();
    bit seen; logic e, b; logic [17:0] ex, ob;
    devFlag = 1'b0; autoFlag = 1'b0;
    startJob(8'd1, 8'd1, 8'h22);
    sendBytes(2, 8'h30, 0);
    pushArm(8'h00);
    repeat (20) @(negedge clk);
    checkCount++;
    if ({busy, bus.ide_cs, bus.ide_oe, bus.ide_we, bus.ide_a} !== {4'b1110, 10'h006})
      $display("[TB] FAIL abort_in_wait: got busy/cs/oe/we=%b a=%h, expected 1110 006", {busy, bus.ide_cs, bus.ide_oe, bus.ide_we}, bus.ide_a);
    else passCount++;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expQ.push_back({10'h001, 8'h04});
    expQ.push_back({10'h000, 8'h51});
    waitDone(50, seen, e, b);
    checkCount++;
    if (seen !== 1'b1 || {e, b} !== 2'b10)
      $display("[TB] FAIL abort_done: got seen=%b err=%b busy=%b, expected 1 1 0", seen, e, b);
    else passCount++;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++;
    if ({busy, done} !== 2'b00) $display("[TB] FAIL abort_idle: got busy/done=%b, expected 00", {busy, done});
    else passCount++;
    startJob(8'd0, 8'd5, 8'h99);
    checkCount++;
    if (busy !== 1'b1) $display("[TB] FAIL zero_busy: got %b, expected 1", busy);
    else passCount++;
    expQ.push_back({10'h000, 8'h99});
    waitDone(20, seen, e, b);
    checkCount++;
    if (seen !== 1'b1 || {e, b} !== 2'b00)
      $display("[TB] FAIL zero_done: got seen=%b err=%b busy=%b, expected 1 0 0", seen, e, b);
    else passCount++;
    while (expQ.size() > 0) begin
      ex = expQ.pop_front();
      checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL abort_write: got none, expected a=%h d=%h", ex[17:8], ex[7:0]);
      else begin
        ob = obsQ.pop_front();
        if (ob !== ex) $display("[TB] FAIL abort_write: got a=%h d=%h, expected a=%h d=%h", ob[17:8], ob[7:0], ex[17:8], ex[7:0]);
        else passCount++;
      end
    end
    checkCount++;
    if (obsQ.size() != 0) $display("[TB] FAIL abort_extra: got %0d extra writes, expected 0", obsQ.size());
    else passCount++;
    obsQ.delete();
  endtask

  task automatic test_reset_mid_fill();
    bit seen; logic e, b; logic [17:0] ex, ob;
    devFlag = 1'b0; autoFlag = 1'b1;
    startJob(8'd1, 8'd4, 8'h44);
    sendBytes(5, 8'h50, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({busy, done, err, srcReady, bus.ide_cs, bus.ide_oe, bus.ide_we, bus.ide_a, bus.ide_d_out} !== 25'd0)
      $display("[TB] FAIL midfill_reset: got busy/done/err/rdy=%b cs/oe/we=%b a=%h d=%h, expected all 0",
               {busy, done, err, srcReady}, {bus.ide_cs, bus.ide_oe, bus.ide_we}, bus.ide_a, bus.ide_d_out);
    else passCount++;
    startJob(8'd1, 8'd1, 8'h45);
    sendBytes(2, 8'h60, 0);
    pushArm(8'h00);
    expQ.push_back({10'h006, 8'h20});
    expQ.push_back({10'h000, 8'h45});
    waitDone(100, seen, e, b);
    checkCount++;
    if (seen !== 1'b1 || {e, b} !== 2'b00)
      $display("[TB] FAIL midfill_restart_done: got seen=%b err=%b busy=%b, expected 1 0 0", seen, e, b);
    else passCount++;
    while (expQ.size() > 0) begin
      ex = expQ.pop_front();
      checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL midfill_write: got none, expected a=%h d=%h", ex[17:8], ex[7:0]);
      else begin
        ob = obsQ.pop_front();
        if (ob !== ex) $display("[TB] FAIL midfill_write: got a=%h d=%h, expected a=%h d=%h", ob[17:8], ob[7:0], ex[17:8], ex[7:0]);
        else passCount++;
      end
    end
    checkCount++;
    if (obsQ.size() != 0) $display("[TB] FAIL midfill_extra: got %0d extra writes, expected 0", obsQ.size());
    else passCount++;
    obsQ.delete();
  endtask

  task automatic test_wait_hold();
    bit seen; logic e, b; logic [17:0] ex, ob;
    devFlag = 1'b0; autoFlag = 1'b0;
    startJob(8'd1, 8'd1, 8'h5A);
    sendBytes(2, 8'h70, 0);
    pushArm(8'h00);
`ifdef IDE_SEQ_WATCHDOG_EN
    begin
      int waitCycles;
      waitCycles = 0; seen = 1'b0; e = 1'bx;
      for (int c = 0; c < 70000 && !seen; c++) begin
        @(negedge clk);
        if (busy && bus.ide_oe && bus.ide_a == 10'h006) waitCycles++;
        if (done) begin seen = 1'b1; e = err; end
      end
      checkCount++;
      if (seen !== 1'b1 || e !== 1'b1 || waitCycles != 65535)
        $display("[TB] FAIL watchdog_timeout: got done=%b err=%b wait_cycles=%0d, expected 1 1 65535", seen, e, waitCycles);
      else passCount++;
    end
`else
    repeat (3000) @(negedge clk);
    checkCount++;
    if ({busy, bus.ide_oe, bus.ide_a} !== {2'b11, 10'h006})
      $display("[TB] FAIL wait_hold: got busy/oe=%b a=%h, expected 11 006", {busy, bus.ide_oe}, bus.ide_a);
    else passCount++;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    waitDone(50, seen, e, b);
    checkCount++;
    if (seen !== 1'b1 || {e, b} !== 2'b10)
      $display("[TB] FAIL wait_hold_abort: got seen=%b err=%b busy=%b, expected 1 1 0", seen, e, b);
    else passCount++;
`endif
    expQ.push_back({10'h001, 8'h04});
    expQ.push_back({10'h000, 8'h51});
    while (expQ.size() > 0) begin
      ex = expQ.pop_front();
      checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL wait_write: got none, expected a=%h d=%h", ex[17:8], ex[7:0]);
      else begin
        ob = obsQ.pop_front();
        if (ob !== ex) $display("[TB] FAIL wait_write: got a=%h d=%h, expected a=%h d=%h", ob[17:8], ob[7:0], ex[17:8], ex[7:0]);
        else passCount++;
      end
    end
    checkCount++;
    if (obsQ.size() != 0) $display("[TB] FAIL wait_extra: got %0d extra writes, expected 0", obsQ.size());
    else passCount++;
    obsQ.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no summary by 2ms, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    nchunks = 8'd0; chunkWords = 8'd0; finalStatus = 8'd0;
    srcData = 8'd0; srcValid = 1'b0;
    bus.cpu_a = 10'h000; bus.cpu_d_in = 8'h00;
    bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0; bus.cpu_we = 1'b0;
    bus.ide_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single_chunk();
    test_multi_chunk_256();
    test_cpu_arbitration();
    test_abort_and_zero();
    test_reset_mid_fill();
    test_wait_hold();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
